// File: rtl/cdma_correlator.sv
// Integrate-and-dump despreader: counts ones over one gold-code period,
// takes a majority decision, and tracks lock and weak-decision statistics.
module cdma_correlator #(
    parameter int CHIPS  = 31,
    parameter int MARGIN = 8,
    parameter int LOCK_N = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       chip_i,
    input  logic       chip_en_i,
    input  logic       sync_i,
    output logic       bit_o,
    output logic       bit_valid_o,
    output logic       lock_o,
    output logic [7:0] err_cnt_o
);

    localparam int IDXW = $clog2(CHIPS);
    localparam int CW   = $clog2(CHIPS + 1);

    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(CHIPS - 1);
    localparam logic [CW-1:0]   HALF      = CW'((CHIPS - 1) / 2);
    localparam logic [CW-1:0]   STRONG_HI = CW'(CHIPS - MARGIN);
    localparam logic [CW-1:0]   STRONG_LO = CW'(MARGIN);
    localparam logic [3:0]      LOCK_MAX  = 4'(LOCK_N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_INTEG = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic [3:0]      lock_cnt_q, lock_cnt_d;
    logic            bit_q, bit_d;
    logic            bit_valid_q, bit_valid_d;
    logic            lock_q, lock_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [CW-1:0]   chip_ext_s;
    logic [CW-1:0]   total_s;
    logic            strong_s;

    assign chip_ext_s = {{(CW-1){1'b0}}, chip_i};
    assign total_s    = ones_q + chip_ext_s;
    assign strong_s   = (total_s >= STRONG_HI) || (total_s <= STRONG_LO);

    // Next-state: sync restarts the symbol; the last chip produces a decision.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        lock_cnt_d  = lock_cnt_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        lock_d      = lock_q;
        err_cnt_d   = err_cnt_q;
        if (sync_i) begin
            state_d = ST_INTEG;
            if (chip_en_i) begin
                idx_d  = {{(IDXW-1){1'b0}}, 1'b1};
                ones_d = chip_ext_s;
            end else begin
                idx_d  = '0;
                ones_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_INTEG: begin
                    if (chip_en_i && (idx_q == IDX_LAST)) begin
                        idx_d       = '0;
                        ones_d      = '0;
                        bit_valid_d = 1'b1;
                        bit_d       = (total_s > HALF);
                        if (strong_s) begin
                            if (lock_cnt_q == LOCK_MAX) begin
                                lock_cnt_d = lock_cnt_q;
                            end else begin
                                lock_cnt_d = lock_cnt_q + 4'd1;
                            end
                        end else begin
                            lock_cnt_d = 4'd0;
                            if (err_cnt_q == 8'hFF) begin
                                err_cnt_d = err_cnt_q;
                            end else begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end
                        lock_d = (lock_cnt_d == LOCK_MAX);
                    end else if (chip_en_i) begin
                        idx_d  = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                        ones_d = total_s;
                    end else begin
                        idx_d  = idx_q;
                        ones_d = ones_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ones_q      <= '0;
            lock_cnt_q  <= 4'd0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            lock_cnt_q  <= lock_cnt_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            lock_q      <= lock_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bit_o       = bit_q;
    assign bit_valid_o = bit_valid_q;
    assign lock_o      = lock_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cdma_correlator.sv
// Bench for cdma_correlator: directed scenarios plus randomized traffic,
// all compared every cycle against a symbol-level reference model.
module tb_cdma_correlator;

    localparam int CHIPS  = 31;
    localparam int MARGIN = 8;
    localparam int LOCK_N = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       chip_i = 1'b0;
    logic       chip_en_i = 1'b0;
    logic       sync_i = 1'b0;
    logic       bit_o;
    logic       bit_valid_o;
    logic       lock_o;
    logic [7:0] err_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a started flag, the chips of the open symbol, and stats.
    bit m_started = 1'b0;
    bit sym_q[$];
    int m_bit = 0, m_valid = 0, m_lock = 0, m_lock_cnt = 0, m_err = 0;

    cdma_correlator #(.CHIPS(CHIPS), .MARGIN(MARGIN), .LOCK_N(LOCK_N)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .chip_i     (chip_i),
        .chip_en_i  (chip_en_i),
        .sync_i     (sync_i),
        .bit_o      (bit_o),
        .bit_valid_o(bit_valid_o),
        .lock_o     (lock_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit s, input bit e, input bit c, input bit r);
        int t;
        if (r) begin
            m_started = 1'b0;
            sym_q.delete();
            m_bit = 0; m_valid = 0; m_lock = 0; m_lock_cnt = 0; m_err = 0;
            return;
        end
        m_valid = 0;
        if (s) begin
            m_started = 1'b1;
            sym_q.delete();
            if (e) sym_q.push_back(c);
        end else if (m_started && e) begin
            sym_q.push_back(c);
            if (sym_q.size() == CHIPS) begin
                t = 0;
                foreach (sym_q[i]) t += int'(sym_q[i]);
                sym_q.delete();
                m_valid = 1;
                m_bit = (t > (CHIPS - 1) / 2) ? 1 : 0;
                if (t >= CHIPS - MARGIN || t <= MARGIN) begin
                    m_lock_cnt = (m_lock_cnt < LOCK_N) ? m_lock_cnt + 1 : LOCK_N;
                end else begin
                    m_lock_cnt = 0;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end
                m_lock = (m_lock_cnt == LOCK_N) ? 1 : 0;
            end
        end
    endtask

    task automatic step(input bit s, input bit e, input bit c, input bit r);
        @(negedge clk);
        sync_i = s; chip_en_i = e; chip_i = c; rst_i = r;
        @(posedge clk);
        #1;
        model_update(s, e, c, r);
        check("bit_o", int'(bit_o), m_bit);
        check("bit_valid_o", int'(bit_valid_o), m_valid);
        check("lock_o", int'(lock_o), m_lock);
        check("err_cnt_o", int'(err_cnt_o), m_err);
    endtask

    // Full contiguous symbol: first n_ones chips are 1, the rest 0.
    task automatic send_symbol(input int n_ones);
        for (int i = 0; i < CHIPS; i++) step(1'b0, 1'b1, (i < n_ones), 1'b0);
    endtask

    initial begin
        int p;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_all", {31'd0, bit_o} + {31'd0, bit_valid_o} + {31'd0, lock_o} + int'(err_cnt_o), 0);

        // Chips before the first sync must be ignored.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_sync_err", int'(err_cnt_o), 0);

        // All-ones symbol.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_symbol(31);
        check("ones_valid", int'(bit_valid_o), 1);
        check("ones_bit", int'(bit_o), 1);
        check("ones_err", int'(err_cnt_o), 0);

        // Borderline 16/15 symbol is weak.
        send_symbol(16);
        check("weak_bit", int'(bit_o), 1);
        check("weak_err", int'(err_cnt_o), 1);
        check("weak_lock", int'(lock_o), 0);

        // Four all-zero symbols lock, a 12-one symbol unlocks.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_symbol(0);
            check("zero_bit", int'(bit_o), 0);
        end
        check("lock_rise", int'(lock_o), 1);
        send_symbol(12);
        check("lock_fall", int'(lock_o), 0);
        check("unlock_err", int'(err_cnt_o), 2);

        // Re-sync after 20 chips discards the partial symbol.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("resync_no_early", int'(bit_valid_o), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("resync_strobe", int'(bit_valid_o), 1);

        // Gapped chip enable produces the same decision.
        for (int i = 0; i < 2 * CHIPS; i++) step(1'b0, (i % 2) == 0, 1'b1, 1'b0);
        check("gapped_bit", int'(bit_o), 1);

        // Sync coinciding with the final chip wins: no strobe.
        for (int i = 0; i < CHIPS - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sync_priority", int'(bit_valid_o), 0);

        // Reach err=3 and lock, then reset mid-symbol.
        send_symbol(31);
        send_symbol(16);
        for (int k = 0; k < 4; k++) send_symbol(0);
        check("pre_rst_lock", int'(lock_o), 1);
        check("pre_rst_err", int'(err_cnt_o), 3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_lock", int'(lock_o), 0);
        check("rst_err", int'(err_cnt_o), 0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_err", int'(err_cnt_o), 0);

        // Error counter saturation.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 260; k++) send_symbol(15);
        check("err_sat", int'(err_cnt_o), 255);

        // Randomized traffic with rare syncs and resets.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        p = 50;
        for (int n = 0; n < 12000; n++) begin
            if ((n % 250) == 0) begin
                case ($urandom_range(0, 4))
                    0: p = 0;
                    1: p = 3;
                    2: p = 50;
                    3: p = 97;
                    default: p = 100;
                endcase
            end
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < p,
                 $urandom_range(0, 2999) == 0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/cdma_correlator.md
CDMA_CORRELATOR -- requirements
Module: cdma_correlator

Interface
REQ-001 SHALL have parameter CHIPS, default 31, meaning chips per data bit (one full gold-code period); legal range 3..255, odd.
REQ-002 SHALL have parameter MARGIN, default 8, meaning max minority-chip count for a decision to be "strong"; legal 0..(CHIPS-1)/2.
REQ-003 SHALL have parameter LOCK_N, default 4, meaning consecutive strong decisions required for lock; legal 1..15.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset: synchronous, active-high.
REQ-006 SHALL have port chip_i, input, 1, meaning the despread chip (the spreader's receptor output, i.e. received chip XOR gold).
REQ-007 SHALL have port chip_en_i, input, 1, meaning chip_i is valid this cycle.
REQ-008 SHALL have port sync_i, input, 1, meaning symbol boundary, pulsed together with the gold-generator seed load.
REQ-009 SHALL have port bit_o, output, 1, meaning decided data bit.
REQ-010 SHALL have port bit_valid_o, output, 1, meaning one-cycle strobe qualifying bit_o.
REQ-011 SHALL have port lock_o, output, 1, meaning correlator is locked.
REQ-012 SHALL have port err_cnt_o, output, 8, meaning saturating count of weak decisions.

Function
REQ-013 SHALL implement FSM states IDLE and INTEG; IDLE->INTEG on sync_i; INTEG stays INTEG; any state->IDLE only on rst_i.
REQ-014 SHALL, in IDLE, ignore chip_en_i/chip_i entirely.
REQ-015 SHALL keep chip index idx (0..CHIPS-1) and ones counter ones (width clog2(CHIPS+1)).
REQ-016 SHALL, on sync_i in any state, set idx=0, ones=0 and discard any partial symbol with no bit_valid_o; if chip_en_i is also high that cycle, that chip is accepted as index 0 (idx->1, ones->chip_i).
REQ-017 SHALL, in INTEG with chip_en_i=1 and sync_i=0, add chip_i to ones and increment idx; chip_en_i=0 cycles hold all counters.
REQ-018 SHALL, when the chip with idx==CHIPS-1 is accepted, form total T=ones+chip_i, wrap idx to 0, clear ones, and stay in INTEG (next symbol contiguous, no new sync needed).
REQ-019 SHALL assert bit_valid_o for exactly one cycle, the cycle after the final chip is accepted (latency 1), with bit_o=1 iff T>(CHIPS-1)/2.
REQ-020 SHALL hold bit_o at its last decided value between strobes.
REQ-021 SHALL classify a decision strong iff T>=CHIPS-MARGIN or T<=MARGIN, else weak.
REQ-022 SHALL update lock count with the strobe: strong -> increment, saturating at LOCK_N; weak -> clear to 0.
REQ-023 SHALL drive lock_o=1 iff lock count==LOCK_N, registered, changing in the same cycle as bit_valid_o.
REQ-024 SHALL increment err_cnt_o on each weak decision, saturating at 255, never wrapping.
REQ-025 SHALL leave lock count, lock_o and err_cnt_o unchanged by sync_i.
REQ-026 SHALL give sync_i priority when it coincides with the final chip: symbol discarded, no strobe.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, set state=IDLE, idx=0, ones=0, lock count=0, bit_o=0, bit_valid_o=0, lock_o=0, err_cnt_o=0; rst_i overrides sync_i and chip_en_i.
REQ-028 SHALL, on reset mid-symbol, discard the partial symbol and require a fresh sync_i before accepting chips.

Verification
REQ-029 SHALL pass: sync_i, then 31 chips all 1 with chip_en_i continuous -> bit_valid_o pulse one cycle after 31st chip, bit_o=1, err_cnt_o=0.
REQ-030 SHALL pass: 16 ones + 15 zeros -> bit_o=1, weak, err_cnt_o 0->1, lock_o=0.
REQ-031 SHALL pass: sync_i then 4 contiguous all-0 symbols -> bit_o=0 each, lock_o rises with 4th strobe; a following 12-one symbol -> lock_o falls, err_cnt_o+1.
REQ-032 SHALL pass: sync_i re-pulsed after 20 chips -> no strobe; strobe only 31 accepted chips after second sync.
REQ-033 SHALL pass: chip_en_i toggling 1/0 (31 chips over 62 cycles) -> identical decision to continuous case; chips before first sync ignored.
REQ-034 SHALL pass: rst_i at chip 10 while locked and err_cnt_o=3 -> all outputs 0 next cycle, chips ignored until sync_i.
